// File: rtl/exe_stage.sv
// Execute stage of the 8-bit RISC pipeline: operand forwarding, ALU, Z/N flags,
// branch resolution and the EXE/WB result register.
// Optional iterative multiplier (opcode F) is built when EXE_MUL_EN is defined;
// without it opcode F behaves as a NOP and busy is tied low.
module exe_stage #(
    parameter int unsigned DW      = 8,
    parameter int unsigned RW      = 2,
    parameter int unsigned MUL_CYC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [3:0]    opcode,
    input  logic [RW-1:0] ra_addr,
    input  logic [RW-1:0] rb_addr,
    input  logic [DW-1:0] ra_data,
    input  logic [DW-1:0] rb_data,
    input  logic [DW-1:0] imm,
    input  logic          wb_we,
    input  logic [RW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          busy,
    output logic          ex_valid,
    output logic          ex_we,
    output logic [RW-1:0] ex_rd,
    output logic [DW-1:0] ex_result,
    output logic [1:0]    flags_zn,
    output logic          br_taken,
    output logic [DW-1:0] br_target
);

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_MOV = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_BRZ = 4'hC;
    localparam logic [3:0] OP_BRN = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_MUL = 4'hF;

    // The shift-add multiplier walks one bit of B per cycle.
    if (MUL_CYC != DW) begin : g_cfg_check
        $error("exe_stage: MUL_CYC must equal DW");
    end

    logic [DW-1:0] op_a_c;
    logic [DW-1:0] op_b_c;
    logic [DW-1:0] alu_res_c;
    logic          alu_we_c;
    logic          alu_flag_c;
    logic          alu_taken_c;

    // Operand forwarding: EXE/WB register first, then writeback port, then register file.
    always_comb begin
        op_a_c = ra_data;
        op_b_c = rb_data;
        if (ex_valid && ex_we && (ex_rd == ra_addr)) begin
            op_a_c = ex_result;
        end else if (wb_we && (wb_addr == ra_addr)) begin
            op_a_c = wb_data;
        end
        if (ex_valid && ex_we && (ex_rd == rb_addr)) begin
            op_b_c = ex_result;
        end else if (wb_we && (wb_addr == rb_addr)) begin
            op_b_c = wb_data;
        end
    end

    // Single-cycle ALU, write enable, flag update enable and branch decision.
    always_comb begin
        alu_res_c   = '0;
        alu_we_c    = 1'b0;
        alu_flag_c  = 1'b0;
        alu_taken_c = 1'b0;
        case (opcode)
            OP_ADD: begin alu_res_c = op_a_c + op_b_c;       alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_SUB: begin alu_res_c = op_a_c - op_b_c;       alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_AND: begin alu_res_c = op_a_c & op_b_c;       alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_OR:  begin alu_res_c = op_a_c | op_b_c;       alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_XOR: begin alu_res_c = op_a_c ^ op_b_c;       alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_NOT: begin alu_res_c = ~op_a_c;               alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_SHL: begin alu_res_c = op_a_c << imm[2:0];    alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_SHR: begin alu_res_c = op_a_c >> imm[2:0];    alu_we_c = 1'b1; alu_flag_c = 1'b1; end
            OP_LDI: begin alu_res_c = imm;                   alu_we_c = 1'b1; end
            OP_MOV: begin alu_res_c = op_a_c;                alu_we_c = 1'b1; end
            OP_CMP: begin alu_res_c = op_a_c - op_b_c;       alu_flag_c = 1'b1; end
            OP_BRZ: alu_taken_c = flags_zn[1];
            OP_BRN: alu_taken_c = flags_zn[0];
            OP_JMP: alu_taken_c = 1'b1;
            default: ;
        endcase
    end

`ifdef EXE_MUL_EN
    localparam int unsigned CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t        state;
    state_t        state_d;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [DW-1:0] acc_nxt_c;
    logic          mul_last_c;

    // Multiplier FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, busy and the shift-add step.
    always_comb begin
        state_d    = state;
        busy       = 1'b0;
        mul_last_c = (cnt == CW'(MUL_CYC - 1));
        acc_nxt_c  = acc + (mul_b[cnt] ? (mul_a << cnt) : '0);
        case (state)
            S_IDLE: begin
                if (in_valid && (opcode == OP_MUL) && !rst) begin
                    busy    = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (mul_last_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
`else
    assign busy = 1'b0;
`endif

    // EXE/WB register, flags and branch redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_we     <= 1'b0;
            ex_rd     <= '0;
            ex_result <= '0;
            flags_zn  <= 2'b00;
            br_taken  <= 1'b0;
            br_target <= '0;
`ifdef EXE_MUL_EN
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            br_taken <= 1'b0;
`ifdef EXE_MUL_EN
            if (state == S_MUL) begin
                if (mul_last_c) begin
                    ex_valid  <= 1'b1;
                    ex_we     <= 1'b1;
                    ex_result <= acc_nxt_c;
                    flags_zn  <= {acc_nxt_c == '0, acc_nxt_c[DW-1]};
                end else begin
                    ex_valid  <= 1'b0;
                    ex_we     <= 1'b0;
                end
                acc <= acc_nxt_c;
                cnt <= cnt + CW'(1);
            end else if (in_valid && (opcode == OP_MUL)) begin
                mul_a    <= op_a_c;
                mul_b    <= op_b_c;
                acc      <= '0;
                cnt      <= '0;
                ex_valid <= 1'b0;
                ex_we    <= 1'b0;
                ex_rd    <= rb_addr;
            end else
`endif
            if (in_valid) begin
                ex_valid  <= 1'b1;
                ex_we     <= alu_we_c;
                ex_rd     <= rb_addr;
                ex_result <= alu_res_c;
                if (alu_flag_c) begin
                    flags_zn <= {alu_res_c == '0, alu_res_c[DW-1]};
                end
                if (alu_taken_c) begin
                    br_taken  <= 1'b1;
                    br_target <= imm;
                end
            end else begin
                ex_valid <= 1'b0;
                ex_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a scoreboard of expected EXE/WB outputs.
// Covers the multiplier only when EXE_MUL_EN is defined.
module tb_exe_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] opcode;
    logic [1:0] ra_addr, rb_addr;
    logic [7:0] ra_data, rb_data, imm;
    logic       wb_we;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       busy, ex_valid, ex_we, br_taken;
    logic [1:0] ex_rd, flags_zn;
    logic [7:0] ex_result, br_target;

    typedef struct {
        logic       valid;
        logic       we;
        logic [1:0] rd;
        logic [7:0] res;
        logic       chk_res;
        logic [1:0] flags;
        logic       br;
        logic [7:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   sid      = 0;

    exe_stage #(.DW(8), .RW(2), .MUL_CYC(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .imm(imm), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd(ex_rd),
        .ex_result(ex_result), .flags_zn(flags_zn), .br_taken(br_taken),
        .br_target(br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [7:0] rad, input logic [7:0] rbd,
                         input logic [7:0] im, input logic wwe, input logic [1:0] wa,
                         input logic [7:0] wd);
        @(negedge clk);
        in_valid = v;  opcode  = op;  ra_addr = ra;  rb_addr = rb;
        ra_data  = rad; rb_data = rbd; imm    = im;
        wb_we    = wwe; wb_addr = wa;  wb_data = wd;
    endtask

    task automatic expect_out(input logic v, input logic we, input logic [1:0] rd,
                              input logic [7:0] res, input logic cr, input logic [1:0] fl,
                              input logic br, input logic [7:0] tgt);
        exp_t e;
        e.valid = v; e.we = we; e.rd = rd; e.res = res; e.chk_res = cr;
        e.flags = fl; e.br = br; e.tgt = tgt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        sid++;
        chk($sformatf("s%0d_sb_nonempty", sid), 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("s%0d_ex_valid", sid), 32'(ex_valid), 32'(e.valid));
            chk($sformatf("s%0d_ex_we", sid), 32'(ex_we), 32'(e.we));
            chk($sformatf("s%0d_flags_zn", sid), 32'(flags_zn), 32'(e.flags));
            chk($sformatf("s%0d_br_taken", sid), 32'(br_taken), 32'(e.br));
            if (e.we)      chk($sformatf("s%0d_ex_rd", sid), 32'(ex_rd), 32'(e.rd));
            if (e.chk_res) chk($sformatf("s%0d_ex_result", sid), 32'(ex_result), 32'(e.res));
            if (e.br)      chk($sformatf("s%0d_br_target", sid), 32'(br_target), 32'(e.tgt));
        end
    endtask

    task automatic step_check();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_ex_valid"},  32'(ex_valid),  32'd0);
        chk({tag, "_ex_we"},     32'(ex_we),     32'd0);
        chk({tag, "_ex_rd"},     32'(ex_rd),     32'd0);
        chk({tag, "_ex_result"}, 32'(ex_result), 32'd0);
        chk({tag, "_flags_zn"},  32'(flags_zn),  32'd0);
        chk({tag, "_br_taken"},  32'(br_taken),  32'd0);
        chk({tag, "_br_target"}, 32'(br_target), 32'd0);
    endtask

`ifdef EXE_MUL_EN
    // Wait for a multiply to complete, counting busy cycles and result edges.
    task automatic mul_wait(input string tag);
        int n_edges = 0;
        int n_busy  = 0;
        bit done    = 0;
        #1;
        if (busy) n_busy++;
        while (!done && n_edges < 20) begin
            @(posedge clk);
            #1;
            n_edges++;
            if (ex_valid) begin
                done = 1;
            end else begin
                @(negedge clk);
                #1;
                if (busy) n_busy++;
            end
        end
        chk({tag, "_edges"}, 32'(n_edges), 32'd9);
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'd9);
        pop_check();
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; opcode = 4'h0; ra_addr = '0; rb_addr = '0;
        ra_data = '0; rb_data = '0; imm = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        #12;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // ADD 0x7F+0x01 -> 0x80, N set
        drive(1, 4'h1, 2'd0, 2'd1, 8'h7F, 8'h01, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd1, 8'h80, 1, 2'b01, 0, 8'h00); step_check();
        // SUB 5-5 -> 0, Z set
        drive(1, 4'h2, 2'd2, 2'd3, 8'h05, 8'h05, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd3, 8'h00, 1, 2'b10, 0, 8'h00); step_check();
        // ADD writes r2 = 0x10
        drive(1, 4'h1, 2'd0, 2'd2, 8'h08, 8'h08, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd2, 8'h10, 1, 2'b00, 0, 8'h00); step_check();
        // MOV r2 with stale RF and a competing WB: EXE/WB value wins
        drive(1, 4'hA, 2'd2, 2'd0, 8'h00, 8'h00, 8'h00, 1, 2'd2, 8'h77);
        expect_out(1, 1, 2'd0, 8'h10, 1, 2'b00, 0, 8'h00); step_check();
        // MOV r3 matched only by WB
        drive(1, 4'hA, 2'd3, 2'd1, 8'h00, 8'h00, 8'h00, 1, 2'd3, 8'h5A);
        expect_out(1, 1, 2'd1, 8'h5A, 1, 2'b00, 0, 8'h00); step_check();
        // Bubble
        drive(0, 4'h1, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 8'h00);
        expect_out(0, 0, 2'd0, 8'h00, 0, 2'b00, 0, 8'h00); step_check();
        // CMP equal -> Z, no write
        drive(1, 4'hB, 2'd0, 2'd1, 8'h33, 8'h33, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 0, 2'd1, 8'h00, 0, 2'b10, 0, 8'h00); step_check();
        // BRZ taken to 0x3C
        drive(1, 4'hC, 2'd0, 2'd0, 8'h00, 8'h00, 8'h3C, 0, 2'd0, 8'h00);
        expect_out(1, 0, 2'd0, 8'h00, 0, 2'b10, 1, 8'h3C); step_check();
        // BRN with N=0 not taken; br_taken also drops after one cycle
        drive(1, 4'hD, 2'd0, 2'd0, 8'h00, 8'h00, 8'h55, 0, 2'd0, 8'h00);
        expect_out(1, 0, 2'd0, 8'h00, 0, 2'b10, 0, 8'h00); step_check();
        // LDI holds flags
        drive(1, 4'h9, 2'd0, 2'd2, 8'h00, 8'h00, 8'h80, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd2, 8'h80, 1, 2'b10, 0, 8'h00); step_check();
        // SHL 0x11 by 3 -> 0x88
        drive(1, 4'h7, 2'd1, 2'd3, 8'h11, 8'h00, 8'h03, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd3, 8'h88, 1, 2'b01, 0, 8'h00); step_check();
        // SHR 0x90 by imm[2:0]=4 -> 0x09
        drive(1, 4'h8, 2'd1, 2'd0, 8'h90, 8'h00, 8'hFC, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd0, 8'h09, 1, 2'b00, 0, 8'h00); step_check();
        // XOR
        drive(1, 4'h5, 2'd2, 2'd3, 8'hF0, 8'hFF, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd3, 8'h0F, 1, 2'b00, 0, 8'h00); step_check();
        // NOT 0 -> 0xFF
        drive(1, 4'h6, 2'd1, 2'd1, 8'h00, 8'h00, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd1, 8'hFF, 1, 2'b01, 0, 8'h00); step_check();
        // JMP
        drive(1, 4'hE, 2'd0, 2'd0, 8'h00, 8'h00, 8'hA5, 0, 2'd0, 8'h00);
        expect_out(1, 0, 2'd0, 8'h00, 0, 2'b01, 1, 8'hA5); step_check();
        // BRN with N=1 taken
        drive(1, 4'hD, 2'd0, 2'd0, 8'h00, 8'h00, 8'h12, 0, 2'd0, 8'h00);
        expect_out(1, 0, 2'd0, 8'h00, 0, 2'b01, 1, 8'h12); step_check();
        // AND
        drive(1, 4'h3, 2'd0, 2'd2, 8'hCC, 8'hAA, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd2, 8'h88, 1, 2'b01, 0, 8'h00); step_check();
        // OR
        drive(1, 4'h4, 2'd0, 2'd3, 8'h0C, 8'h30, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd3, 8'h3C, 1, 2'b00, 0, 8'h00); step_check();
        // SUB wrap 1-2 -> 0xFF
        drive(1, 4'h2, 2'd2, 2'd0, 8'h01, 8'h02, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd0, 8'hFF, 1, 2'b01, 0, 8'h00); step_check();

`ifdef EXE_MUL_EN
        // MUL 0x0D*0x0B -> 0x8F
        drive(1, 4'hF, 2'd2, 2'd1, 8'h0D, 8'h0B, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd1, 8'h8F, 1, 2'b01, 0, 8'h00);
        mul_wait("mul_8f");
        // MUL 0x10*0x10 -> 0x00, Z
        drive(1, 4'hF, 2'd2, 2'd3, 8'h10, 8'h10, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd3, 8'h00, 1, 2'b10, 0, 8'h00);
        mul_wait("mul_zero");
        // Reset in the middle of a multiply (counter at 3)
        drive(1, 4'hF, 2'd0, 2'd2, 8'h03, 8'h03, 8'h00, 0, 2'd0, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_state("rst_mid_mul");
`else
        // Opcode F without the multiplier: NOP with ex_valid=1, flags held
        drive(1, 4'hF, 2'd0, 2'd1, 8'h0D, 8'h0B, 8'h00, 0, 2'd0, 8'h00);
        #1;
        chk("opf_busy", 32'(busy), 32'd0);
        expect_out(1, 0, 2'd1, 8'h00, 0, 2'b01, 0, 8'h00); step_check();
        // Asynchronous reset with non-zero state present
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_state("rst_async");
`endif
        @(negedge clk);
        rst = 1'b0;
        // ADD accepted after reset
        drive(1, 4'h1, 2'd0, 2'd1, 8'h01, 8'h02, 8'h00, 0, 2'd0, 8'h00);
        expect_out(1, 1, 2'd1, 8'h03, 1, 2'b00, 0, 8'h00); step_check();
        drive(0, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 0, 2'd0, 8'h00);
        expect_out(0, 0, 2'd0, 8'h00, 0, 2'b00, 0, 8'h00); step_check();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
